reg_file_mp: RTL and testbench

REG_FILE_MP -- requirements
Module: reg_file_mp

---
 rtl/reg_file_mp.sv | 121 ++++++++++++
 tb/tb_reg_file_mp.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-read-port register file with a post-reset clearing sweep.
// After reset an INIT sweep zeroes registers 1..DEPTH-1, one per cycle, and
// the file then enters READY. Register 0 is hardwired to zero.
//
// Ports:
//   clk            single clock, rising edge
//   rst            synchronous active-high reset
//   write_back_en  write request for the current cycle
//   wr_addr        write register index
//   wr_data        write data
//   r_addr         packed read indices, port k at [k*ADDR_WIDTH +: ADDR_WIDTH]
//   r_data         packed read data, port k at [k*DATA_WIDTH +: DATA_WIDTH]
//   init_done      high once the clearing sweep has finished
//   wr_dropped     one-cycle pulse for each write discarded during INIT
//
// Optional feature: define REG_FILE_BYPASS_EN to forward a same-cycle write
// to matching read ports (write-through). Without it, reads return the
// pre-write value in the write cycle.
module reg_file_mp #(
    parameter int ADDR_WIDTH   = 5,
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_RD_PORTS = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               write_back_en,
    input  logic [ADDR_WIDTH-1:0]              wr_addr,
    input  logic [DATA_WIDTH-1:0]              wr_data,
    input  logic [NUM_RD_PORTS*ADDR_WIDTH-1:0] r_addr,
    output logic [NUM_RD_PORTS*DATA_WIDTH-1:0] r_data,
    output logic                               init_done,
    output logic                               wr_dropped
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {
        INIT,
        READY
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [ADDR_WIDTH-1:0] cnt_nxt;
    logic                  drop_nxt;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic wr_fire;
    assign wr_fire = (state == READY) && write_back_en
                     && (wr_addr != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= INIT;
            cnt        <= ADDR_WIDTH'(1);
            wr_dropped <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            wr_dropped <= drop_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        drop_nxt  = 1'b0;
        unique case (state)
            INIT: begin
                cnt_nxt  = cnt + ADDR_WIDTH'(1);
                drop_nxt = write_back_en;
                // the edge that clears the last register also ends INIT
                if (cnt == '1) begin
                    state_nxt = READY;
                end
            end
            READY: begin
                state_nxt = READY;
            end
            default: begin
                state_nxt = INIT;
            end
        endcase
    end

    // Contents are left untouched while rst is held; only the sweep clears.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == INIT) begin
                mem[cnt] <= '0;
            end else if (wr_fire) begin
                mem[wr_addr] <= wr_data;
            end
        end
    end

    assign init_done = (state == READY);

    for (genvar k = 0; k < NUM_RD_PORTS; k++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra;
        logic [DATA_WIDTH-1:0] rv;

        assign ra = r_addr[k*ADDR_WIDTH +: ADDR_WIDTH];

        always_comb begin
            rv = mem[ra];
`ifdef REG_FILE_BYPASS_EN
            if (wr_fire && (ra == wr_addr)) begin
                rv = wr_data;
            end
`endif
            if (rst || (state != READY) || (ra == '0)) begin
                rv = '0;
            end
        end

        assign r_data[k*DATA_WIDTH +: DATA_WIDTH] = rv;
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: directed plus randomized checks of reg_file_mp against
// a behavioural array model of the register file.
module tb_reg_file_mp;

    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int NP    = 2;
    localparam int DEPTH = 2 ** AW;

    logic               clk;
    logic               rst;
    logic               write_back_en;
    logic [AW-1:0]      wr_addr;
    logic [DW-1:0]      wr_data;
    logic [NP*AW-1:0]   r_addr;
    logic [NP*DW-1:0]   r_data;
    logic               init_done;
    logic               wr_dropped;

    reg_file_mp #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .NUM_RD_PORTS(NP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .write_back_en(write_back_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .r_addr       (r_addr),
        .r_data       (r_data),
        .init_done    (init_done),
        .wr_dropped   (wr_dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: register contents, readiness, cycles swept so far.
    logic [DW-1:0] ref_mem [DEPTH];
    bit            ref_ready;
    int            ref_swept;
    bit            ref_drop;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a);
        if (rst || !ref_ready || a == 0) return '0;
`ifdef REG_FILE_BYPASS_EN
        if (write_back_en && a == wr_addr) return wr_data;
`endif
        return ref_mem[a];
    endfunction

    task automatic check_all();
        for (int k = 0; k < NP; k++) begin
            chk($sformatf("rd%0d[x%0d]", k, r_addr[k*AW +: AW]),
                r_data[k*DW +: DW], exp_read(r_addr[k*AW +: AW]));
        end
        chk("init_done", {31'b0, init_done}, {31'b0, ref_ready});
        chk("wr_dropped", {31'b0, wr_dropped}, {31'b0, ref_drop});
    endtask

    // Check the current cycle, advance the model, then cross the edge.
    task automatic step();
        #1;
        check_all();
        if (rst) begin
            ref_ready = 0;
            ref_swept = 0;
            ref_drop  = 0;
        end else if (!ref_ready) begin
            ref_swept++;
            ref_mem[ref_swept] = '0;
            ref_drop = write_back_en;
            if (ref_swept == DEPTH - 1) ref_ready = 1;
        end else begin
            ref_drop = 0;
            if (write_back_en && wr_addr != 0) ref_mem[wr_addr] = wr_data;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        r_addr = {a1, a0};
    endtask

    task automatic idle();
        write_back_en = 0;
        wr_addr       = '0;
        wr_data       = '0;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        write_back_en = 1;
        wr_addr       = a;
        wr_data       = d;
    endtask

    task automatic sweep(input int inject_at, output int n);
        n = 0;
        while (!init_done && n < 100) begin
            if (n == inject_at) wr(AW'(9), 32'hCAFE0009);
            else idle();
            step();
            n++;
        end
        idle();
    endtask

    int n;

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 'x;
        ref_ready = 0;
        ref_swept = 0;
        ref_drop  = 0;
        rst = 1;
        idle();
        set_rd(5'd0, 5'd0);
        @(posedge clk);
        #1;

        // Reset held with a write request: nothing dropped, reads zero.
        wr(AW'(3), 32'h0BADF00D);
        set_rd(5'd3, 5'd7);
        step();
        step();
        idle();

        // Sweep with a write request in sweep cycle 3.
        rst = 0;
        sweep(2, n);
        chk("init_cycles", DW'(n), DW'(31));

        for (int i = 0; i < DEPTH; i += 2) begin
            set_rd(AW'(i), AW'(i + 1));
            step();
        end
        set_rd(5'd9, 5'd9);
        #1;
        chk("x9_after_drop", r_data[DW-1:0], 32'h0);

        wr(AW'(5), 32'hDEADBEEF);
        set_rd(5'd1, 5'd2);
        step();
        idle();
        set_rd(5'd5, 5'd5);
        #1;
        chk("x5_p0", r_data[DW-1:0], 32'hDEADBEEF);
        chk("x5_p1", r_data[2*DW-1:DW], 32'hDEADBEEF);
        step();

        wr(AW'(0), 32'h12345678);
        set_rd(5'd0, 5'd0);
        step();
        idle();
        #1;
        chk("x0_p0", r_data[DW-1:0], 32'h0);
        chk("x0_p1", r_data[2*DW-1:DW], 32'h0);
        step();

        wr(AW'(7), 32'h11111111);
        step();
        wr(AW'(7), 32'hA5A5A5A5);
        set_rd(5'd0, 5'd7);
        #1;
`ifdef REG_FILE_BYPASS_EN
        chk("x7_same_cycle", r_data[2*DW-1:DW], 32'hA5A5A5A5);
`else
        chk("x7_same_cycle", r_data[2*DW-1:DW], 32'h11111111);
`endif
        step();
        idle();
        #1;
        chk("x7_next_cycle", r_data[2*DW-1:DW], 32'hA5A5A5A5);
        step();

        for (int i = 0; i < 400; i++) begin
            write_back_en = 1'($urandom);
            wr_addr       = AW'($urandom);
            wr_data       = $urandom;
            r_addr        = (NP*AW)'($urandom);
            if (i % 4 == 0) r_addr[AW-1:0] = wr_addr;
            step();
        end
        idle();

        // Reset in READY, then again at sweep cycle 10.
        rst = 1;
        step();
        rst = 0;
        for (int i = 0; i < 10; i++) step();
        rst = 1;
        step();
        rst = 0;
        sweep(-1, n);
        chk("reinit_cycles", DW'(n), DW'(31));
        set_rd(5'd5, 5'd7);
        #1;
        chk("x5_cleared", r_data[DW-1:0], 32'h0);
        chk("x7_cleared", r_data[2*DW-1:DW], 32'h0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
